shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit controller for the ALU shift path: accepts one shift request, then applies a log-step shift (stage k shifts by 2^k when shamt[k]=1) over successive cycles.
- Returns the result on a valid/ready handshake.
- Sits between the ALU operand select and the writeback mux. It replaces the one-cycle case-decoded shifter for SLL/SRL/SRA when area is favoured over latency.

Parameters:
- N, 32, data width; must be a power of two.
- SW, $clog2(N) (5), shift-amount width and number of shift stages.
- EARLY_EXIT, 0, 0 = fixed latency of SW stage cycles; 1 = finish as soon as no set shamt bits remain.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; pipeline squash.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_a  input  N  operand to shift.
- in_shamt  input  SW  shift amount; only SW bits exist (RV32I semantics, 0..31).
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SLL).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_r  output  N  shifted result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, stage counter k=0, out_valid=0, out_r=0, internal operand/shamt/op registers=0. in_ready=1 and busy=0 while reset is held.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). It is combinational from state only, with no dependence on in_valid.
- IDLE:
  - On in_valid && in_ready, latch in_a into the working register acc, and latch shamt and op. Set k=0 and go to SHIFT.
  - Exception: if EARLY_EXIT=1 and in_shamt==0, load acc=in_a and go directly to DONE.
- SHIFT, each edge:
  - If shamt[k]=1, acc becomes acc shifted by 2^k: left with zero fill (SLL), right with zero fill (SRL), or right with fill of acc[N-1] (SRA). Sign is preserved because every stage is arithmetic.
  - If shamt[k]=0, acc is unchanged.
  - Then k increments.
  - Fixed mode: after the k=SW-1 edge, go to DONE.
  - EARLY_EXIT=1: go to DONE after the first edge where shamt bits above k are all zero.
- Latency from the acceptance edge to out_valid high:
  - Fixed mode: exactly SW edges (5).
  - EARLY_EXIT: h+1 edges, where h is the index of the highest set shamt bit; 0 extra edges when shamt==0.
- DONE: out_valid=1 and out_r=acc, held stable until out_valid && out_ready. On that edge, go to IDLE and drop out_valid. The earliest next acceptance is the following cycle; there is no same-cycle turnaround.
- out_r keeps its last value after the handshake and is not cleared. Only reset clears it.
- Inputs in_a, in_shamt and in_op are ignored outside the acceptance cycle. Changes during SHIFT or DONE have no effect.
- flush (priority over all handshakes): at the next edge, from any state, go to IDLE, out_valid=0 and k=0. Any result is discarded. A request presented with flush=1 in IDLE is not accepted.
- rst_n asserted mid-operation: immediate return to reset values without waiting for the clock edge. No result is produced.
- out_valid and in_ready are never high together.

Test Plan:
- Fixed mode, SLL, in_a=0x0000_0001, shamt=31 → out_r=0x8000_0000, out_valid rises exactly 5 edges after acceptance, busy high throughout.
- SRA, in_a=0x8000_0000, shamt=4 → 0xF800_0000. SRL with the same inputs → 0x0800_0000. op=10, in_a=0x1, shamt=3 → 0x0000_0008.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → out_r and out_valid stay stable and in_ready stays 0. Raise out_ready → IDLE next edge, then a new request is accepted the following cycle.
- Flush at stage k=2 of SLL 0xFFFF_FFFF by 7 → IDLE next edge, no out_valid pulse. A subsequent SRL 0xF0 by 4 returns 0x0F.
- Async reset: drop rst_n mid-SHIFT → out_valid=0, in_ready=1, out_r=0 immediately. Release, then SLL 0x3 by 1 returns 0x6.
- EARLY_EXIT=1:
  - shamt=0, in_a=0x1234_5678 → out_valid right after acceptance, out_r=0x1234_5678.
  - shamt=3 → out_valid 2 edges after acceptance.
  - shamt=16 → out_valid 5 edges after acceptance.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle log-step shifter for SLL/SRL/SRA. Stage k shifts by 2^k when shamt[k] is set.
// The result is returned on a valid/ready handshake.
module shift_sequencer #(
  parameter int unsigned N          = 32,
  parameter int unsigned SW         = $clog2(N),
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_shamt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_r,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_d;
  logic [SW-1:0] k, k_d;
  logic [SW-1:0] shamt, shamt_d;
  logic [SW-1:0] step;
  logic [1:0]    op, op_d;
  logic [N-1:0]  acc, acc_d;
  logic [N-1:0]  stage_out;
  logic [N-1:0]  out_r_d;
  logic          out_valid_d;
  logic          last_stage;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One log-step stage; op 2'b10 is reserved and executes as SLL.
  always_comb begin
    step      = SW'(1) << k;
    stage_out = acc;
    if (shamt[k]) begin
      case (op)
        2'b01:   stage_out = acc >> step;
        2'b11:   stage_out = N'($signed(acc) >>> step);
        default: stage_out = acc << step;
      endcase
    end
  end

  // Early exit stops once no set shamt bits remain above the current stage.
  assign last_stage = EARLY_EXIT ? (((shamt >> k) >> 1) == '0) : (k == SW'(SW - 1));

  always_comb begin
    state_d     = state;
    k_d         = k;
    shamt_d     = shamt;
    op_d        = op;
    acc_d       = acc;
    out_valid_d = out_valid;
    out_r_d     = out_r;
    if (flush) begin
      state_d     = IDLE;
      k_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_d   = in_a;
            shamt_d = in_shamt;
            op_d    = in_op;
            k_d     = '0;
            if (EARLY_EXIT && (in_shamt == '0)) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_r_d     = in_a;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_d = stage_out;
          k_d   = k + 1'b1;
          if (last_stage) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_r_d     = stage_out;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      shamt     <= '0;
      op        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      shamt     <= shamt_d;
      op        <= op_d;
      acc       <= acc_d;
      out_valid <= out_valid_d;
      out_r     <= out_r_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: instance 0 is fixed latency, instance 1 has early exit enabled.
module tb_shift_sequencer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       flush, in_valid, out_ready;
  logic [1:0]       in_ready, out_valid, busy;
  logic [1:0][31:0] in_a, out_r;
  logic [1:0][4:0]  in_shamt;
  logic [1:0][1:0]  in_op;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(32), .EARLY_EXIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]),
    .in_shamt(in_shamt[0]), .in_op(in_op[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_r(out_r[0]),
    .busy(busy[0])
  );

  shift_sequencer #(.N(32), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]),
    .in_shamt(in_shamt[1]), .in_op(in_op[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_r(out_r[1]),
    .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepting edge, then scramble the inputs.
  task automatic send(input int d, input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op);
    in_valid[d] = 1'b1;
    in_a[d]     = a;
    in_shamt[d] = sh;
    in_op[d]    = op;
    tick();
    in_valid[d] = 1'b0;
    in_a[d]     = ~a;
    in_shamt[d] = ~sh;
    in_op[d]    = ~op;
  endtask

  task automatic run(input int d, input string tag, input logic [31:0] a, input logic [4:0] sh,
                     input logic [1:0] op, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    bit busy_ok;
    send(d, a, sh, op);
    lat     = 0;
    busy_ok = 1'b1;
    while (!out_valid[d] && lat < 20) begin
      if (!busy[d] || in_ready[d]) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_r"}, out_r[d], exp_r);
    check({tag, "_busy"}, {31'd0, busy_ok & busy[d] & ~in_ready[d]}, 32'd1);
  endtask

  task automatic finish_req(input int d, input string tag);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check({tag, "_ovalid_drop"}, {31'd0, out_valid[d]}, 32'd0);
    check({tag, "_idle"}, {30'd0, in_ready[d], busy[d]}, 32'd2);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    in_a      = '0;
    in_shamt  = '0;
    in_op     = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
      check("rst_busy", {31'd0, busy[d]}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
      check("rst_out_r", out_r[d], 32'd0);
    end
    #10 rst_n = 1'b1;
    tick();

    run(0, "sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 5);
    finish_req(0, "sll31");
    run(0, "sll0", 32'h0000_00A5, 5'd0, 2'b00, 32'h0000_00A5, 5);
    finish_req(0, "sll0");

    run(0, "sra4", 32'h8000_0000, 5'd4, 2'b11, 32'hF800_0000, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ovalid", {31'd0, out_valid[0]}, 32'd1);
      check("bp_out_r", out_r[0], 32'hF800_0000);
      check("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
    end
    finish_req(0, "sra4");
    check("keep_out_r", out_r[0], 32'hF800_0000);
    run(0, "op10", 32'h0000_0001, 5'd3, 2'b10, 32'h0000_0008, 5);
    finish_req(0, "op10");

    run(0, "srl4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000, 5);
    finish_req(0, "srl4");

    send(0, 32'hFFFF_FFFF, 5'd7, 2'b00);
    tick();
    tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    check("flush_busy", {31'd0, busy[0]}, 32'd0);
    check("flush_ovalid", {31'd0, out_valid[0]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[0]) seen = 1'b1;
    end
    check("flush_no_result", {31'd0, seen}, 32'd0);
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    tick();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    check("flush_blocks_accept", {31'd0, busy[0]}, 32'd0);
    run(0, "srl_f0", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 5);
    finish_req(0, "srl_f0");

    send(0, 32'h0000_0001, 5'd9, 2'b00);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ovalid", {31'd0, out_valid[0]}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("arst_out_r", out_r[0], 32'd0);
    check("arst_busy", {31'd0, busy[0]}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    run(0, "sll3", 32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, 5);
    finish_req(0, "sll3");

    run(1, "ee0", 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678, 0);
    finish_req(1, "ee0");
    run(1, "ee3", 32'h0000_0001, 5'd3, 2'b00, 32'h0000_0008, 2);
    finish_req(1, "ee3");
    run(1, "ee16", 32'h8000_0000, 5'd16, 2'b11, 32'hFFFF_8000, 5);
    finish_req(1, "ee16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
